serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/full_adder.sv | 17 +
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and small helpers.
package serial_adder_pkg;

  // State encoding. 2'd3 is never entered; the next-state logic maps it to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A new request may be taken from IDLE or straight out of DONE (back-to-back).
  function automatic logic can_accept(input state_t st);
    return (st == S_IDLE) || (st == S_DONE);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term shared by the sum and carry equations.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, one
// bit per clock, framed by a start/busy/done handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; sum/cout hold the last result
// ADD    | one bit per cycle, LSB first, WIDTH cycles total
// DONE   | one-cycle done pulse; may accept a new start immediately
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_cout;
  logic             load;
  logic             last_bit;
  logic [WIDTH-1:0] acc_next;

  full_adder u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Handshake decode: request acceptance and the final-bit cycle of ADD.
  always_comb begin
    load     = start && can_accept(state_q);
    last_bit = (state_q == S_ADD) && (cnt_q == LAST_BIT);
    acc_next = {fa_s, acc_q[WIDTH-1:1]};
  end

  // State register; reset overrides any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_ADD : S_IDLE;
      S_ADD:   state_d = last_bit ? S_DONE : S_ADD;
      S_DONE:  state_d = start ? S_ADD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand shift registers, serial sum accumulator, carry and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      acc_q   <= '0;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == S_ADD) begin
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      acc_q   <= acc_next;
      carry_q <= fa_cout;
      // Hold at the terminal count so the counter never wraps mid-operation.
      if (!last_bit) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Result registers: written only on the edge that enters DONE, so the
  // previous result stays visible through IDLE and the following ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (last_bit) begin
      sum_q  <= acc_next;
      cout_q <= fa_cout;
    end
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy = (state_q == S_ADD);
    done = (state_q == S_DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): handshake timing, carry edge
// cases, result hold, ignored mid-ADD start, reset abort and back-to-back.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int errors;
  int done_cnt;

  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation starting in the current cycle (cycle 0). Operands are
  // scrambled after the accepting edge to show they were sampled.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec);
    a = ta; b = tb; cin = tc; start = 1'b1;
    for (int c = 1; c <= WIDTH + 1; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
      end
      check({tag, "_busy"}, busy, (c <= WIDTH));
      check({tag, "_done"}, done, (c == WIDTH + 1));
      if (c == 4) begin
        check({tag, "_hold_sum"}, sum, prev_sum);
        check({tag, "_hold_cout"}, cout, prev_cout);
      end
    end
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    prev_sum = es;
    prev_cout = ec;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    rst = 1'b0;
    tick();

    run_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("opffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Idle hold: result persists, no stray done.
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_done", done, 1'b0);
      check("hold_sum", sum, 8'hFF);
      check("hold_cout", cout, 1'b1);
    end

    // A start pulse in the middle of ADD must be ignored.
    done_cnt = 0;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 4) begin start = 1'b1; a = 8'h10; b = 8'h10; end
      if (c == 5) start = 1'b0;
      if (done) done_cnt++;
      if (c == 9) begin
        check("ign_done", done, 1'b1);
        check("ign_sum", sum, 8'h02);
        check("ign_cout", cout, 1'b0);
      end
    end
    check("ign_done_count", done_cnt, 1);

    // Reset mid-ADD aborts with no done pulse.
    done_cnt = 0;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 3) rst = 1'b1;
    end
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check("abort_no_activity", done_cnt, 0);

    // Reset and start together: the request is dropped.
    rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    check("rststart_busy", busy, 1'b0);
    check("rststart_done", done, 1'b0);

    // Back-to-back with start held high: done every WIDTH+1 cycles.
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    for (int c = 1; c <= 3 * (WIDTH + 1); c++) begin
      tick();
      check("b2b_done", done, ((c % (WIDTH + 1)) == 0));
      if ((c % (WIDTH + 1)) == 0) begin
        check("b2b_sum", sum, 8'h00);
        check("b2b_cout", cout, 1'b1);
      end
    end
    start = 1'b0;
    tick();
    check("b2b_end_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
